// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Iteration counter width: enough to hold 0..width-1 with a spare bit.
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_div_32bit_if.sv
// Request/result bundle between a divider client and the divider.
interface seq_div_32bit_if #(
    parameter int WIDTH = div_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_step.sv
// One combinational radix-2 restoring iteration: shift in a dividend bit, trial-subtract.
module div_step #(
    parameter int WIDTH = div_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] r,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] r_next,
    output logic             q_bit
);
    logic [WIDTH:0] trial;

    // r < divisor on entry, so the difference always fits back into WIDTH bits.
    assign trial  = {r, bit_in};
    assign q_bit  = (trial >= {1'b0, divisor});
    assign r_next = q_bit ? (trial[WIDTH-1:0] - divisor) : trial[WIDTH-1:0];
endmodule

// File: rtl/seq_div_32bit.sv
// Iterative signed/unsigned restoring divider: WIDTH steps, then sign fixup and output load.
module seq_div_32bit
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    seq_div_32bit_if.slave    bus
);
    localparam int CNT_W = cnt_w(WIDTH);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   dvd, dvs, rem, quo, rem_next, abs_a, abs_b;
    logic [WIDTH-1:0]   quotient_r, remainder_r;
    logic               q_bit, sa, sb, sign_q, sign_r, zero_div;
    logic               accept, last_step, done_r, dbz_r;

    assign sa    = bus.is_signed & bus.a[WIDTH-1];
    assign sb    = bus.is_signed & bus.b[WIDTH-1];
    assign abs_a = sa ? -bus.a : bus.a;
    assign abs_b = sb ? -bus.b : bus.b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r       (rem),
        .bit_in  (dvd[WIDTH-1]),
        .divisor (dvs),
        .r_next  (rem_next),
        .q_bit   (q_bit)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_next = state;
        accept     = 1'b0;
        last_step  = (cnt == CNT_W'(WIDTH - 1));
        unique case (state)
            // A request coinciding with the done pulse is deliberately not taken.
            IDLE: if (bus.start && !done_r) begin
                accept     = 1'b1;
                state_next = (bus.b == '0) ? FIX : DIV;
            end
            DIV:     if (last_step) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        // NOTE: datapath registers carry no reset; acceptance always loads them before use.
        if (accept) begin
            sign_q   <= sa ^ sb;
            sign_r   <= sa;
            zero_div <= (bus.b == '0);
            dvd      <= (bus.b == '0) ? bus.a : abs_a;
            dvs      <= abs_b;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
        end else if (state == DIV) begin
            rem <= rem_next;
            quo <= {quo[WIDTH-2:0], q_bit};
            dvd <= {dvd[WIDTH-2:0], 1'b0};
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_r      <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (state == FIX) begin
                done_r <= 1'b1;
                dbz_r  <= zero_div;
                if (zero_div) begin
                    quotient_r  <= '1;
                    remainder_r <= dvd;
                end else begin
                    quotient_r  <= sign_q ? -quo : quo;
                    remainder_r <= sign_r ? -rem : rem;
                end
            end
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_div_32bit.sv
// Directed and randomized checks of seq_div_32bit against a plain-arithmetic reference.
module tb_seq_div_32bit;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   t0  = 0;
    int   checks = 0;
    int   errors = 0;

    seq_div_32bit_if #(.WIDTH(32)) bus ();

    seq_div_32bit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // C-style truncating division computed in 64-bit signed arithmetic.
    function automatic res_t model(input logic [31:0] av, input logic [31:0] bv, input logic sv);
        res_t   res;
        longint na, nb;
        if (bv == 32'd0) begin
            res.q = 32'hFFFF_FFFF;
            res.r = av;
            res.z = 1'b1;
        end else if (!sv) begin
            res.q = av / bv;
            res.r = av % bv;
            res.z = 1'b0;
        end else begin
            na    = longint'($signed(av));
            nb    = longint'($signed(bv));
            res.q = 32'(na / nb);
            res.r = 32'(na % nb);
            res.z = 1'b0;
        end
        return res;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [31:0] av, input logic [31:0] bv, input logic sv);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.a         = av;
        bus.b         = bv;
        bus.is_signed = sv;
        @(posedge clk);
        #1;
        t0            = cyc;
        bus.start     = 1'b0;
        bus.a         = $urandom;
        bus.b         = $urandom;
        bus.is_signed = 1'($urandom);
        check("busy_after_start", {31'd0, bus.busy}, 32'd1);
    endtask

    // Returns in the done cycle, 1 time unit after the edge that raised done.
    task automatic finish(input logic [31:0] eq, input logic [31:0] er, input logic ez,
                          input int exp_lat, input string tag);
        bit seen    = 1'b0;
        bit busy_ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({tag, "_latency"}, cyc - t0, exp_lat);
        check({tag, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
        check({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_quotient"}, bus.quotient, eq);
        check({tag, "_remainder"}, bus.remainder, er);
        check({tag, "_div_by_zero"}, {31'd0, bus.div_by_zero}, {31'd0, ez});
    endtask

    task automatic idle_gap(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, {31'd0, bus.done}, 32'd0);
    endtask

    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                          input logic [31:0] eq, input logic [31:0] er, input logic ez,
                          input string tag);
        launch(av, bv, sv);
        finish(eq, er, ez, (bv == 32'd0) ? 1 : 33, tag);
        idle_gap(tag);
    endtask

    initial begin
        res_t        exp;
        logic [31:0] ra, rb;
        logic        rs;
        int          sel;
        bit          any_done;

        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.a         = '0;
        bus.b         = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_quotient", bus.quotient, 32'd0);
        check("reset_remainder", bus.remainder, 32'd0);
        check("reset_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        rst = 1'b0;

        run_op(32'd255, 32'd32, 1'b0, 32'd7, 32'd31, 1'b0, "unsigned_basic");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "signed_neg_a");
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, "signed_neg_b");
        run_op(32'd43, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd43, 1'b1, "div_zero");
        run_op(32'd43, 32'd7, 1'b0, 32'd6, 32'd1, 1'b0, "after_div_zero");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, "signed_overflow");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'd0, 1'b0, "unsigned_max");

        // A second request mid-operation must be ignored entirely.
        launch(32'd12, 32'd24, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd12;
        bus.b     = 32'd74;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        finish(32'd0, 32'd12, 1'b0, 33, "midop_start");
        idle_gap("midop_start");

        // Request raised in the done cycle is skipped once, then taken while held.
        launch(32'd1000, 32'd7, 1'b0);
        finish(32'd142, 32'd6, 1'b0, 33, "hold_first");
        bus.start     = 1'b1;
        bus.a         = 32'd100;
        bus.b         = 32'd9;
        bus.is_signed = 1'b0;
        @(posedge clk);
        #1;
        check("hold_not_sampled_in_done", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        #1;
        check("hold_accepted_next", {31'd0, bus.busy}, 32'd1);
        t0        = cyc;
        bus.start = 1'b0;
        finish(32'd11, 32'd1, 1'b0, 33, "hold_second");
        idle_gap("hold_second");

        // Reset in the middle of an operation discards it without a done pulse.
        launch(32'd1000, 32'd3, 1'b1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_done", {31'd0, bus.done}, 32'd0);
        check("midrst_quotient", bus.quotient, 32'd0);
        check("midrst_remainder", bus.remainder, 32'd0);
        check("midrst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        rst      = 1'b0;
        any_done = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) any_done = 1'b1;
        end
        check("midrst_no_done", {31'd0, any_done}, 32'd0);
        run_op(32'd74, 32'd12, 1'b0, 32'd6, 32'd2, 1'b0, "after_reset");

        for (int n = 0; n < 24; n++) begin
            ra  = $urandom;
            rb  = $urandom;
            rs  = 1'($urandom);
            sel = $urandom_range(0, 7);
            if (sel == 0)      rb = 32'd0;
            else if (sel < 3)  rb = $urandom_range(1, 255);
            else if (sel == 3) rb = -32'($urandom_range(1, 255));
            else if (sel == 4) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            exp = model(ra, rb, rs);
            run_op(ra, rb, rs, exp.q, exp.r, exp.z, $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_div_32bit.md
Name: seq_div_32bit

Overview:
- Iterative radix-2 restoring divider: the inverse-operation companion to the 32-bit Booth/Wallace multiplier in the arithmetic library.
- Takes dividend and divisor on a start pulse and produces quotient and remainder after a fixed latency, signalled by a done pulse.
- Supports unsigned and signed (two's complement) division, selected per operation.
- Signed results truncate toward zero, C semantics.

Parameters:
- WIDTH, 32, operand/result width in bits (minimum 4).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- is_signed  input  1  1 = signed operation; sampled with start.
- a  input  WIDTH  dividend; sampled with start.
- b  input  WIDTH  divisor; sampled with start.
- busy  output  1  high from the edge after start acceptance until done is asserted.
- done  output  1  one-cycle pulse; results are valid from this cycle.
- quotient  output  WIDTH  registered quotient; holds until the next done.
- remainder  output  WIDTH  registered remainder; holds until the next done.
- div_by_zero  output  1  registered flag qualifying the current results.

Behaviour:
- Clocking and reset: one clock domain (clk). rst is synchronous, active-high, and overrides everything, including mid-operation.
  - On reset: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - An operation in flight is discarded silently and no done is produced.
- States:
  - IDLE: waiting for start.
  - DIV: one iteration per cycle.
  - FIX: sign correction and output load.
- IDLE with start=1 at edge T, b!=0:
  - Latch |a| and |b|; a field is negated only if is_signed=1 and its MSB=1.
  - Latch sign_q = sa XOR sb and sign_r = sa.
  - Clear the partial remainder and iteration counter; go to DIV; busy=1.
- IDLE with start=1 at edge T, b==0:
  - Go directly to FIX with the zero-divide result: quotient = all ones, remainder = a unchanged, div_by_zero=1.
  - done=1 after edge T+1.
- DIV, edges T+1..T+WIDTH, one restoring step per edge:
  - Form r' = {r[WIDTH-1:0], dividend MSB}, a WIDTH+1-bit trial value; shift the dividend left.
  - If r' >= |b|: r = r' - |b|, shift in q bit 1.
  - Otherwise: r = r', shift in q bit 0.
  - The counter runs 0..WIDTH-1; go to FIX after the last step.
- FIX, edge T+WIDTH+1:
  - quotient = sign_q ? -q : q.
  - remainder = sign_r ? -r : r.
  - div_by_zero=0, done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: done is high in the cycle after edge T+WIDTH+1 (33 edges for WIDTH=32); throughput is one operation per WIDTH+2 cycles.
- start while busy=1 is ignored: no queueing, and in-flight operands are unaffected.
- start asserted in the same cycle as done is not sampled, because the FSM is still in FIX. A back-to-back request must be held one more cycle.
- a, b and is_signed may change freely after the start cycle.
- Signed overflow (MIN / -1): |MIN| = 2^(WIDTH-1) as unsigned, so the result is quotient=MIN, remainder=0, div_by_zero=0. No special case is needed; this behaviour is required.
- Invariant (b!=0): a == quotient*b + remainder (mod 2^WIDTH). |remainder| < |b|. remainder takes the sign of a or is zero.
- is_signed=0: all values are unsigned; sign_q = sign_r = 0.

Decomposition:
- Package div_pkg:
  - state enum {IDLE, DIV, FIX}.
  - Default WIDTH constant.
  - Counter width CNT_W = $clog2(WIDTH)+1.
- Sub-module div_step: purely combinational single restoring iteration.
  - Inputs: r, next dividend bit, |b|.
  - Outputs: r_next, q_bit.
  - Keeps the iteration reusable for a later unrolled/pipelined variant.
- The top holds the FSM, counter, operand registers and sign fixup.

Test Plan:
- Unsigned basic: a=255, b=32, is_signed=0, start one cycle -> 33 cycles later done=1, quotient=7, remainder=31, div_by_zero=0; busy high for the intervening cycles.
- Signed truncation: a=-7 (0xFFFFFFF9), b=2, is_signed=1 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Repeat with a=7, b=-2 -> quotient=-3, remainder=1.
- Divide by zero: a=43, b=0 -> done on the second edge, quotient=0xFFFFFFFF, remainder=43, div_by_zero=1. The next valid op (a=43, b=7) clears the flag: quotient=6, remainder=1.
- Overflow and large unsigned: signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0. Unsigned 0xFFFFFFFF / 0xFFFFFFFF -> quotient=1, remainder=0.
- Protocol: pulse start again mid-operation with a=12, b=74 -> ignored, and the original result (12/24 -> 0 r 12) is delivered unchanged. Start held through the done cycle -> accepted the next cycle.
- Reset mid-operation: rst at iteration 10 -> all outputs 0 the next cycle, no done pulse. A subsequent 74/12 completes normally with quotient=6, remainder=2.
